// File: rtl/motion_window_gen.sv
// motion_window_gen
//   Streaming 3x3 neighbourhood generator for the binary motion map. Pixels
//   arrive in raster order, the two previous rows are held in a 1-bit delay
//   line, and one 9-bit window is emitted per pixel centre. After the last
//   pixel of a frame the final row is flushed internally, so every frame
//   yields exactly IMG_WIDTH*IMG_HEIGHT windows.
//
//   Optional build macro: MOTION_WIN_PAD_ONES_EN
//     defined   -> out-of-frame taps read 1
//     undefined -> out-of-frame taps read 0 (default)
//
//   Ports
//     clk           rising-edge clock
//     rst           synchronous active-high reset
//     in_valid      motion_pixel valid
//     in_ready      input accepted when in_valid && in_ready
//     motion_pixel  motion bit of current raster pixel
//     win_valid     one-cycle strobe, window outputs valid
//     motion_map    3x3 window, bit0 top-left .. bit4 centre .. bit8 bottom-right
//     center_x/y    window centre coordinates
//     win_last      final window of the frame
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for first pixel of a frame, counters at zero
//   FILL  | buffering first row + 2 pixels, no windows yet
//   RUN   | one window per accepted pixel
//   FLUSH | input stalled, zeros shifted in to finish the last row
module motion_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          motion_pixel,
  output logic                          win_valid,
  output logic [8:0]                    motion_map,
  output logic [$clog2(IMG_WIDTH)-1:0]  center_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] center_y,
  output logic                          win_last
);

  localparam int XW     = $clog2(IMG_WIDTH);
  localparam int YW     = $clog2(IMG_HEIGHT);
  localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int IW     = $clog2(NPIX);
  localparam int FW     = $clog2(IMG_WIDTH + 1);
  localparam int SR_LEN = 2 * IMG_WIDTH + 3;

  localparam logic [XW-1:0] X_LAST        = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST        = YW'(IMG_HEIGHT - 1);
  localparam logic [IW-1:0] IDX_FIRST_WIN = IW'(IMG_WIDTH + 1);
  localparam logic [IW-1:0] IDX_LAST      = IW'(NPIX - 1);
  localparam logic [FW-1:0] FLUSH_LOAD    = FW'(IMG_WIDTH);

`ifdef MOTION_WIN_PAD_ONES_EN
  localparam logic PAD = 1'b1;
`else
  localparam logic PAD = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t            state;
  // The incoming sample is the youngest of the 2*W+3 delay-line samples,
  // so only 2*W+2 of them need to be registered.
  logic [SR_LEN-2:0] sr;
  logic [IW-1:0]     in_idx;
  logic [XW-1:0]     cx;
  logic [YW-1:0]     cy;
  logic [FW-1:0]     flush_cnt;

  logic              xfer;
  logic              din;
  logic              emit;
  logic [SR_LEN-1:0] sr_next;
  logic [8:0]        win_next;
  logic              top_out, bot_out, lft_out, rgt_out;

  assign xfer    = in_valid && in_ready;
  assign din     = (state == FLUSH) ? 1'b0 : motion_pixel;
  assign sr_next = {sr, din};

  assign emit = ((state == FILL) && xfer && (in_idx == IDX_FIRST_WIN)) ||
                ((state == RUN) && xfer) ||
                (state == FLUSH);

  // Window taps come from the post-shift delay line so the window for the
  // current centre is registered in the same edge that completes it.
  // Column masking uses the centre counter, so left/right never wrap.
  always_comb begin
    top_out = (cy == '0);
    bot_out = (cy == Y_LAST);
    lft_out = (cx == '0);
    rgt_out = (cx == X_LAST);
    win_next    = '0;
    win_next[0] = (top_out || lft_out) ? PAD : sr_next[2*IMG_WIDTH+2];
    win_next[1] = top_out              ? PAD : sr_next[2*IMG_WIDTH+1];
    win_next[2] = (top_out || rgt_out) ? PAD : sr_next[2*IMG_WIDTH];
    win_next[3] = lft_out              ? PAD : sr_next[IMG_WIDTH+2];
    win_next[4] = sr_next[IMG_WIDTH+1];
    win_next[5] = rgt_out              ? PAD : sr_next[IMG_WIDTH];
    win_next[6] = (bot_out || lft_out) ? PAD : sr_next[2];
    win_next[7] = bot_out              ? PAD : sr_next[1];
    win_next[8] = (bot_out || rgt_out) ? PAD : sr_next[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      sr         <= '0;
      in_idx     <= '0;
      cx         <= '0;
      cy         <= '0;
      flush_cnt  <= '0;
      win_valid  <= 1'b0;
      motion_map <= '0;
      center_x   <= '0;
      center_y   <= '0;
      win_last   <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;

      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (xfer) begin
            sr     <= sr_next[SR_LEN-2:0];
            in_idx <= IW'(1);
            state  <= FILL;
          end
        end
        FILL: begin
          if (xfer) begin
            sr     <= sr_next[SR_LEN-2:0];
            in_idx <= in_idx + IW'(1);
            if (in_idx == IDX_FIRST_WIN) state <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            sr     <= sr_next[SR_LEN-2:0];
            in_idx <= in_idx + IW'(1);
            if (in_idx == IDX_LAST) begin
              state     <= FLUSH;
              in_ready  <= 1'b0;
              in_idx    <= '0;
              flush_cnt <= FLUSH_LOAD;
            end
          end
        end
        FLUSH: begin
          sr <= sr_next[SR_LEN-2:0];
          if (flush_cnt == '0) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // The centre counters wrap to (0,0) after the last window, leaving
      // them zeroed for IDLE without a separate clear.
      if (emit) begin
        win_valid  <= 1'b1;
        motion_map <= win_next;
        center_x   <= cx;
        center_y   <= cy;
        win_last   <= (cx == X_LAST) && (cy == Y_LAST);
        if (cx == X_LAST) begin
          cx <= '0;
          cy <= (cy == Y_LAST) ? '0 : cy + YW'(1);
        end else begin
          cx <= cx + XW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_motion_window_gen.sv
module tb_motion_window_gen;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
`ifdef MOTION_WIN_PAD_ONES_EN
  localparam bit PAD_V = 1'b1;
`else
  localparam bit PAD_V = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          motion_pixel;
  logic          win_valid;
  logic [8:0]    motion_map;
  logic [XW-1:0] center_x;
  logic [YW-1:0] center_y;
  logic          win_last;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  motion_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .motion_pixel(motion_pixel), .win_valid(win_valid), .motion_map(motion_map),
    .center_x(center_x), .center_y(center_y), .win_last(win_last)
  );

  typedef struct {
    logic [8:0] map;
    int         x;
    int         y;
    logic       last;
    int         stamp;
  } win_t;

  typedef struct {
    int         frame;
    int         x;
    int         y;
    logic [8:0] exp;
  } vec_t;

  win_t wq[$];
  win_t mon_w;
  vec_t tbl[$];
  bit   img[N];
  int   acc_cyc[N];

  always @(negedge clk) begin
    if (win_valid === 1'b1) begin
      mon_w.map   = motion_map;
      mon_w.x     = int'(center_x);
      mon_w.y     = int'(center_y);
      mon_w.last  = win_last;
      mon_w.stamp = cyc;
      wq.push_back(mon_w);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference window: each tap is the pixel at (x+dx, y+dy) or the pad value.
  function automatic logic [8:0] model_win(input int x, input int y);
    logic [8:0] m;
    int px, py;
    m = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        px = x + dx;
        py = y + dy;
        if (px < 0 || px >= W || py < 0 || py >= H) m[(dy+1)*3 + (dx+1)] = PAD_V;
        else m[(dy+1)*3 + (dx+1)] = img[py*W + px];
      end
    end
    return m;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; motion_pixel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst win_valid", win_valid, 0);
    chk("rst motion_map", motion_map, 0);
    chk("rst center_x", center_x, 0);
    chk("rst center_y", center_y, 0);
    chk("rst win_last", win_last, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", in_ready, 1);
  endtask

  task automatic run_frame(input bit gaps, input string tag);
    int  idx, budget, low_cnt, k0, exp_stamp;
    bit  v;
    wq.delete();
    idx = 0;
    budget = 2000;
    while (idx < N && budget > 0) begin
      @(negedge clk);
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      motion_pixel = img[idx];
      if (v && in_ready) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      budget--;
    end
    chk({tag, " accepted"}, idx, N);
    low_cnt = 0;
    budget = 50;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      in_valid = 1'($urandom_range(0, 1));
      motion_pixel = 1'b1;
      low_cnt++;
      budget--;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, " in_ready low cycles"}, low_cnt, W + 1);
    @(negedge clk);
    chk({tag, " window count"}, wq.size(), N);
    k0 = N - W - 2;
    for (int i = 0; i < N && i < wq.size(); i++) begin
      chk($sformatf("%s map %0d", tag, i), wq[i].map, model_win(i % W, i / W));
      chk($sformatf("%s cx %0d", tag, i), wq[i].x, i % W);
      chk($sformatf("%s cy %0d", tag, i), wq[i].y, i / W);
      chk($sformatf("%s last %0d", tag, i), wq[i].last, (i == N - 1) ? 1 : 0);
      exp_stamp = (i <= k0) ? acc_cyc[i + W + 1] + 1 : acc_cyc[N-1] + 1 + (i - k0);
      chk($sformatf("%s timing %0d", tag, i), wq[i].stamp, exp_stamp);
    end
  endtask

  task automatic load_frame(input int f);
    for (int i = 0; i < N; i++) begin
      case (f)
        0:       img[i] = 1'b1;
        1:       img[i] = (i == 1*W + 2);
        2:       img[i] = (i == 1*W + 0);
        default: img[i] = 1'b0;
      endcase
    end
  endtask

  initial begin
    int k;
`ifdef MOTION_WIN_PAD_ONES_EN
    tbl.push_back('{0, 0, 0, 9'h1FF});
    tbl.push_back('{0, 3, 2, 9'h1FF});
    tbl.push_back('{3, 0, 0, 9'b001001111});
    tbl.push_back('{3, 1, 1, 9'h000});
    tbl.push_back('{3, 3, 2, 9'h1E4});
`else
    tbl.push_back('{0, 0, 0, 9'b110110000});
    tbl.push_back('{0, 1, 1, 9'h1FF});
    tbl.push_back('{0, 3, 2, 9'h01B});
    tbl.push_back('{1, 1, 0, 9'h100});
    tbl.push_back('{1, 3, 2, 9'h001});
    tbl.push_back('{1, 3, 1, 9'h008});
    tbl.push_back('{1, 0, 1, 9'h000});
    tbl.push_back('{2, 3, 0, 9'h000});
    tbl.push_back('{2, 0, 0, 9'h080});
    tbl.push_back('{3, 1, 1, 9'h000});
`endif
    tbl.push_back('{1, 2, 1, 9'h010});
    tbl.push_back('{1, 1, 1, 9'h020});

    do_reset();

    for (int f = 0; f < 4; f++) begin
      load_frame(f);
      run_frame(1'b0, $sformatf("frame%0d", f));
      foreach (tbl[j]) begin
        if (tbl[j].frame == f) begin
          k = tbl[j].y * W + tbl[j].x;
          if (k < wq.size()) begin
            chk($sformatf("vec f%0d (%0d,%0d)", f, tbl[j].x, tbl[j].y), wq[k].map, tbl[j].exp);
          end else begin
            checks++;
            errors++;
            $display("FAIL vec f%0d (%0d,%0d): window missing", f, tbl[j].x, tbl[j].y);
          end
        end
      end
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) img[i] = 1'($urandom_range(0, 1));
      run_frame(r[0], $sformatf("rand%0d", r));
    end

    // Abort a frame after 7 pixels, then a clean all-ones frame.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      motion_pixel = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst in_ready", in_ready, 0);
    chk("mid rst win_valid", win_valid, 0);
    wq.delete();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no aborted windows", wq.size(), 0);
    chk("in_ready after mid rst", in_ready, 1);
    load_frame(0);
    run_frame(1'b1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
